// File: rtl/mips_mc.sv
// Multi-cycle MIPS integer core. One shared instruction/data memory port with
// a req/ack handshake. Register file and ALU are kept inside this module.
module mips_mc #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned CNT_W           = 32,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ack,
  output logic [31:0]      pc,
  output logic             halted,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
  logic [31:0]      aluout_q, aluout_d, mdr_q, mdr_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             retire;
  logic [31:0]      rf_q [32];
  logic             rf_we;

  // Instruction fields
  logic [5:0]  op, func;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [31:0] signimm, zeroimm;
  assign op      = ir_q[31:26];
  assign rs      = ir_q[25:21];
  assign rt      = ir_q[20:16];
  assign rd      = ir_q[15:11];
  assign shamt   = ir_q[10:6];
  assign func    = ir_q[5:0];
  assign imm     = ir_q[15:0];
  assign signimm = {{16{imm[15]}}, imm};
  assign zeroimm = {16'h0000, imm};

  logic is_r, is_alu_r, is_sll, is_slt, is_sltu, is_jr, is_movz;
  logic is_lw, is_sw, is_addi, is_addiu, is_ori, is_lui;
  logic is_beq, is_bne, is_bltz, is_blez, is_j, is_jal, is_branch, legal;
  assign is_r      = (op == 6'b000000);
  assign is_alu_r  = is_r && (func[5:3] == 3'b100);
  assign is_sll    = is_r && (func == 6'b000000);
  assign is_slt    = is_r && (func == 6'b101010);
  assign is_sltu   = is_r && (func == 6'b101011);
  assign is_jr     = is_r && (func == 6'b001000);
  assign is_movz   = is_r && (func == 6'b001010);
  assign is_lw     = (op == 6'b100011);
  assign is_sw     = (op == 6'b101011);
  assign is_addi   = (op == 6'b001000);
  assign is_addiu  = (op == 6'b001001);
  assign is_ori    = (op == 6'b001101);
  assign is_lui    = (op == 6'b001111);
  assign is_beq    = (op == 6'b000100);
  assign is_bne    = (op == 6'b000101);
  assign is_bltz   = (op == 6'b000001) && (rt == 5'd0);
  assign is_blez   = (op == 6'b000110) && (rt == 5'd0);
  assign is_j      = (op == 6'b000010);
  assign is_jal    = (op == 6'b000011);
  assign is_branch = is_beq | is_bne | is_bltz | is_blez;
  assign legal     = is_alu_r | is_sll | is_slt | is_sltu | is_jr | is_movz | is_lw | is_sw |
                     is_addi | is_addiu | is_ori | is_lui | is_branch | is_j | is_jal;

  // Register file read ports; $0 is hardwired to zero
  logic [31:0] rf_rs, rf_rt;
  assign rf_rs = (rs == 5'd0) ? 32'h0 : rf_q[rs];
  assign rf_rt = (rt == 5'd0) ? 32'h0 : rf_q[rt];

  // Write-back destination and data
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_en;
  assign wb_addr = is_jal ? 5'd31 : (is_r ? rd : rt);
  assign wb_data = is_lw ? mdr_q : aluout_q;
  assign wb_en   = is_movz ? (b_q == 32'h0) : 1'b1;

  // ALU result for the EXEC stage
  logic [31:0] alu_res;
  always_comb begin
    alu_res = 32'h0;
    if (is_lw || is_sw || is_addi) alu_res = a_q + signimm;
    else if (is_addiu)             alu_res = a_q + zeroimm;
    else if (is_ori)               alu_res = a_q | zeroimm;
    else if (is_lui)               alu_res = {imm, 16'h0000};
    else if (is_sll)               alu_res = b_q << shamt;
    else if (is_slt)               alu_res = {31'h0, $signed(a_q) < $signed(b_q)};
    else if (is_sltu)              alu_res = {31'h0, a_q < b_q};
    else if (is_movz)              alu_res = a_q;
    else if (is_jal)               alu_res = pc_q;
    else if (is_alu_r) begin
      unique case (func[2:0])
        3'b000, 3'b001: alu_res = a_q + b_q;
        3'b010, 3'b011: alu_res = a_q - b_q;
        3'b100:         alu_res = a_q & b_q;
        3'b101:         alu_res = a_q | b_q;
        3'b110:         alu_res = a_q ^ b_q;
        default:        alu_res = ~(a_q | b_q);
      endcase
    end
  end

  // Branch condition; bltz/blez treat a as signed
  logic taken;
  always_comb begin
    taken = 1'b0;
    if (is_beq)       taken = (a_q == b_q);
    else if (is_bne)  taken = (a_q != b_q);
    else if (is_bltz) taken = a_q[31];
    else if (is_blez) taken = a_q[31] | (a_q == 32'h0);
  end

  // Next-state, datapath updates and memory port drive
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    aluout_d  = aluout_q;
    mdr_d     = mdr_q;
    retire    = 1'b0;
    rf_we     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    unique case (state_q)
      StFetch: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
        if (mem_ack) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 32'd4;
          state_d = StDecode;
        end
      end
      StDecode: begin
        a_d = rf_rs;
        b_d = rf_rt;
        if (legal) begin
          state_d = StExec;
        end else if (HALT_ON_ILLEGAL) begin
          state_d = StHalt;
        end else begin
          retire  = 1'b1;
          state_d = StFetch;
        end
      end
      StExec: begin
        aluout_d = alu_res;
        if (is_branch) begin
          if (taken) pc_d = pc_q + {signimm[29:0], 2'b00};
          retire  = 1'b1;
          state_d = StFetch;
        end else if (is_j || is_jal) begin
          pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
          retire  = is_j;
          state_d = is_j ? StFetch : StWb;
        end else if (is_jr) begin
          pc_d    = a_q;
          retire  = 1'b1;
          state_d = StFetch;
        end else if (is_lw || is_sw) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        mem_req   = 1'b1;
        mem_we    = is_sw;
        mem_addr  = aluout_q;
        mem_wdata = b_q;
        if (mem_ack) begin
          if (is_sw) begin
            retire  = 1'b1;
            state_d = StFetch;
          end else begin
            mdr_d   = mem_rdata;
            state_d = StWb;
          end
        end
      end
      StWb: begin
        rf_we   = wb_en;
        retire  = 1'b1;
        state_d = StFetch;
      end
      StHalt: state_d = StHalt;
      default: state_d = StFetch;
    endcase
    // Abandon any request while reset is held
    if (rst) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = 32'h0;
      mem_wdata = 32'h0;
      rf_we     = 1'b0;
    end
  end

  assign instret_d = retire ? instret_q + {{(CNT_W-1){1'b0}}, 1'b1} : instret_q;

  // Architectural and pipeline registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      pc_q      <= RESET_PC;
      ir_q      <= 32'h0;
      a_q       <= 32'h0;
      b_q       <= 32'h0;
      aluout_q  <= 32'h0;
      mdr_q     <= 32'h0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      aluout_q  <= aluout_d;
      mdr_q     <= mdr_d;
      instret_q <= instret_d;
    end
  end

  // Register file write; writes to $0 are dropped
  always_ff @(posedge clk) begin
    if (rf_we && (wb_addr != 5'd0)) rf_q[wb_addr] <= wb_data;
  end

  assign pc      = pc_q;
  assign halted  = (state_q == StHalt);
  assign instret = instret_q;

endmodule
